// File: rtl/hub75_scan_ctrl.sv
// ---------------------------------------------------------------------------
// hub75_scan_ctrl
//
// Scans a 32x32 HUB75 panel (two 16-row halves driven in parallel) out of a
// frame memory. For each row pair the controller fetches every column, shifts
// the top/bottom RGB triplets out on a divided shift clock, then latches the
// row, selects it on rowD and un-blanks the panel for a fixed dwell.
//
// Build option:
//   HUB75_DIM_EN  - adds the dim[1:0] input; the display dwell becomes
//                   max(1, DISPLAY_CYCLES >> dim), with dim sampled when
//                   the display phase begins.
//
// Ports:
//   clk         system clock, all logic on posedge
//   reset       asynchronous active-low reset
//   run         scan enable, only acted on at row boundaries
//   dim         (HUB75_DIM_EN only) brightness shift
//   rd_data     frame memory data {top RGB, bottom RGB}, one clk latency
//   rd_addr     frame memory read address {row, col}
//   RGB1/RGB2   top / bottom half pixel data
//   sclk        panel shift clock (panel samples on rising edge)
//   LAT         panel latch strobe, active high
//   OE          panel output enable, active low
//   rowD        panel row select
//   frame_done  one-clk pulse after the last row's display dwell
// ---------------------------------------------------------------------------
module hub75_scan_ctrl #(
  parameter int COLS           = 32,
  parameter int ROWS_HALF      = 16,
  parameter int CLK_DIV        = 2,
  parameter int DISPLAY_CYCLES = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                run,
`ifdef HUB75_DIM_EN
  input  logic [1:0]                          dim,
`endif
  input  logic [5:0]                          rd_data,
  output logic [$clog2(ROWS_HALF*COLS)-1:0]   rd_addr,
  output logic [2:0]                          RGB1,
  output logic [2:0]                          RGB2,
  output logic                                sclk,
  output logic                                LAT,
  output logic                                OE,
  output logic [$clog2(ROWS_HALF)-1:0]        rowD,
  output logic                                frame_done
);

  localparam int COL_W   = $clog2(COLS);
  localparam int ROW_W   = $clog2(ROWS_HALF);
  localparam int MAX_LEN = (DISPLAY_CYCLES > CLK_DIV) ? DISPLAY_CYCLES : CLK_DIV;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS_HALF - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DISP_LOAD = CNT_W'(DISPLAY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_BLANK,
    S_LATCH,
    S_DISPLAY
  } state_t;

  state_t                               r_state;
  state_t                               w_next;
  logic [CNT_W-1:0]                     r_cnt;
  logic [CNT_W-1:0]                     w_load;
  logic [CNT_W-1:0]                     w_disp_load;
  logic                                 w_cnt_done;
  logic [COL_W-1:0]                     r_col;
  logic [COL_W-1:0]                     w_col_nxt;
  logic [ROW_W-1:0]                     r_row;
  logic [ROW_W-1:0]                     w_row_nxt;
  logic                                 w_frame_end;

  logic [$clog2(ROWS_HALF*COLS)-1:0]    r_rd_addr;
  logic [2:0]                           r_rgb1;
  logic [2:0]                           r_rgb2;
  logic                                 r_sclk;
  logic                                 r_lat;
  logic                                 r_oe;
  logic [ROW_W-1:0]                     r_rowd;
  logic                                 r_frame_done;

  // Counter holds (phase length - 1) and counts down to zero.
  assign w_cnt_done = (r_cnt == '0);

`ifdef HUB75_DIM_EN
  logic [CNT_W-1:0] w_disp_len;

  always_comb begin
    w_disp_len = CNT_W'(DISPLAY_CYCLES) >> dim;
    if (w_disp_len == '0) begin
      w_disp_len = CNT_W'(1);
    end
    w_disp_load = w_disp_len - CNT_W'(1);
  end
`else
  assign w_disp_load = DISP_LOAD;
`endif

  // NOTE: every signal gets a default at the top of an always_comb so no path
  // leaves it unassigned; that is what keeps latches from being inferred.
  always_comb begin
    w_next      = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_frame_end = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        w_next = S_SHIFT_LO;
      end
      S_SHIFT_LO: begin
        if (w_cnt_done) begin
          w_next = S_SHIFT_HI;
        end
      end
      S_SHIFT_HI: begin
        if (w_cnt_done) begin
          if (r_col == COL_LAST) begin
            w_col_nxt = '0;
            w_next    = S_BLANK;
          end else begin
            w_col_nxt = r_col + COL_W'(1);
            w_next    = S_FETCH;
          end
        end
      end
      S_BLANK: begin
        w_next = S_LATCH;
      end
      S_LATCH: begin
        if (w_cnt_done) begin
          w_next = S_DISPLAY;
        end
      end
      S_DISPLAY: begin
        if (w_cnt_done) begin
          if (r_row == ROW_LAST) begin
            w_row_nxt   = '0;
            w_frame_end = 1'b1;
          end else begin
            w_row_nxt = r_row + ROW_W'(1);
          end
          // run is only honoured here, so a row is never cut short.
          w_next = run ? S_FETCH : S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Phase length loaded when a state is entered.
  always_comb begin
    w_load = '0;
    case (w_next)
      S_SHIFT_LO, S_SHIFT_HI, S_LATCH: w_load = DIV_LOAD;
      S_DISPLAY:                       w_load = w_disp_load;
      default:                         w_load = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Every register here drives a panel pin or sequences one, so all are reset
  // to a defined, blanked value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt        <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_rd_addr    <= '0;
      r_rgb1       <= '0;
      r_rgb2       <= '0;
      r_sclk       <= 1'b0;
      r_lat        <= 1'b0;
      r_oe         <= 1'b1;
      r_rowd       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_next != r_state) begin
        r_cnt <= w_load;
      end else if (!w_cnt_done) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      r_col <= w_col_nxt;
      r_row <= w_row_nxt;

      // Address is issued as FETCH begins, using the already-advanced col/row.
      if (w_next == S_FETCH) begin
        r_rd_addr <= {w_row_nxt, w_col_nxt};
      end

      // Memory answers one clk after the address moves, so the pixel is taken
      // at the end of the first SHIFT_LO clk; with CLK_DIV > 1 this leaves
      // the data settled for at least one clk before sclk rises.
      if (r_state == S_SHIFT_LO && r_cnt == DIV_LOAD) begin
        r_rgb1 <= rd_data[5:3];
        r_rgb2 <= rd_data[2:0];
      end

      // Pin levels are decoded from the state being entered, so each pin
      // changes on the same edge as the state and stays glitch-free.
      r_sclk <= (w_next == S_SHIFT_HI);
      r_lat  <= (w_next == S_LATCH);
      r_oe   <= (w_next != S_DISPLAY);

      if (w_next == S_BLANK) begin
        r_rowd <= r_row;
      end

      r_frame_done <= w_frame_end;
    end
  end

  assign rd_addr    = r_rd_addr;
  assign RGB1       = r_rgb1;
  assign RGB2       = r_rgb2;
  assign sclk       = r_sclk;
  assign LAT        = r_lat;
  assign OE         = r_oe;
  assign rowD       = r_rowd;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hub75_scan_ctrl
//
// Scoreboard bench for hub75_scan_ctrl. The stimulus process pushes the
// expected pixels, per-row records (rowD, row period, OE-low length) and
// frame_done times into queues; a negedge monitor pops them whenever the DUT
// shows the matching pin event (sclk rise, LAT rise, OE rise, frame_done).
// The frame memory model returns rd_data = rd_addr[5:0] one clk later.
// Build with +define+HUB75_DIM_EN to exercise the dim port.
// ---------------------------------------------------------------------------
module tb_hub75_scan_ctrl;

  localparam int COLS       = 32;
  localparam int ROWS_HALF  = 16;
  localparam int ROW_CLKS   = 227;    // 32*5 + 1 + 2 + 64
  localparam int FRAME_CLKS = 3632;   // 16 * 227
  localparam int LAT_CLKS   = 2;
`ifdef HUB75_DIM_EN
  localparam int ROW4_OE    = 16;     // 64 >> 2
`else
  localparam int ROW4_OE    = 64;
`endif

  typedef struct {
    int row;
    int period;   // clks since previous LAT rise, 0 = not checked
    int oe_len;
  } row_exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [1:0] dim;
  logic [5:0] rd_data = '0;
  logic [8:0] rd_addr;
  logic [2:0] RGB1;
  logic [2:0] RGB2;
  logic       sclk;
  logic       LAT;
  logic       OE;
  logic [3:0] rowD;
  logic       frame_done;

  hub75_scan_ctrl #(
    .COLS           (COLS),
    .ROWS_HALF      (ROWS_HALF),
    .CLK_DIV        (2),
    .DISPLAY_CYCLES (64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
`ifdef HUB75_DIM_EN
    .dim        (dim),
`endif
    .rd_data    (rd_data),
    .rd_addr    (rd_addr),
    .RGB1       (RGB1),
    .RGB2       (RGB2),
    .sclk       (sclk),
    .LAT        (LAT),
    .OE         (OE),
    .rowD       (rowD),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Frame memory: one clk read latency.
  always @(posedge clk) rd_data <= rd_addr[5:0];

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard queues.
  int       pix_q[$];
  row_exp_t row_q[$];
  int       fd_q[$];

  // Monitor state.
  int       n_sclk = 0;
  int       n_lat  = 0;
  int       n_fd   = 0;
  int       n_disp = 0;
  int       n_oe_low = 0;
  int       sclk_since_lat = 0;
  int       lat_len = 0;
  int       oe_len = 0;
  int       last_lat = 0;
  bit       cur_valid = 1'b0;
  row_exp_t cur;
  logic     p_sclk = 1'b0;
  logic     p_lat  = 1'b0;
  logic     p_oe   = 1'b1;
  logic     p_fd   = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      cur_valid      = 1'b0;
      sclk_since_lat = 0;
    end else begin
      if (!OE) n_oe_low = n_oe_low + 1;

      if (sclk && !p_sclk) begin
        n_sclk         = n_sclk + 1;
        sclk_since_lat = sclk_since_lat + 1;
        check("pixel_expected", pix_q.size() > 0, 1);
        if (pix_q.size() > 0) check("pixel", {RGB1, RGB2}, pix_q.pop_front());
      end

      if (LAT && !p_lat) begin
        n_lat   = n_lat + 1;
        lat_len = 0;
        check("sclk_per_row", sclk_since_lat, COLS);
        sclk_since_lat = 0;
        check("row_expected", row_q.size() > 0, 1);
        if (row_q.size() > 0) begin
          cur       = row_q.pop_front();
          cur_valid = 1'b1;
          check("rowD", rowD, cur.row);
          if (cur.period != 0) check("row_period", cyc - last_lat, cur.period);
        end
        last_lat = cyc;
      end
      if (LAT) begin
        lat_len = lat_len + 1;
        check("lat_blanked", OE, 1);
      end
      if (!LAT && p_lat) check("lat_width", lat_len, LAT_CLKS);

      if (!OE && p_oe) oe_len = 0;
      if (!OE) oe_len = oe_len + 1;
      if (OE && !p_oe) begin
        n_disp = n_disp + 1;
        check("oe_record", cur_valid, 1);
        if (cur_valid) check("oe_low_len", oe_len, cur.oe_len);
        cur_valid = 1'b0;
      end

      if (p_fd) check("frame_done_width", frame_done, 0);
      if (frame_done && !p_fd) begin
        n_fd = n_fd + 1;
        check("frame_done_expected", fd_q.size() > 0, 1);
        if (fd_q.size() > 0) check("frame_done_cycle", cyc, fd_q.pop_front());
        check("wrap_addr", rd_addr, 0);
      end
    end
    p_sclk = sclk;
    p_lat  = LAT;
    p_oe   = OE;
    p_fd   = frame_done;
  end

  task automatic push_row(input int r, input int period, input int oe_l);
    row_exp_t e;
    e.row    = r;
    e.period = period;
    e.oe_len = oe_l;
    row_q.push_back(e);
    for (int c = 0; c < COLS; c++) pix_q.push_back((r * COLS + c) & 63);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  // which: 0 = LAT rises, 1 = frame_done pulses, 2 = display phases ended
  task automatic wait_count(input int which, input int target, input int budget,
                            input string what);
    int i;
    int v;
    i = 0;
    v = (which == 0) ? n_lat : (which == 1) ? n_fd : n_disp;
    while (v < target && i < budget) begin
      tick(1);
      i = i + 1;
      v = (which == 0) ? n_lat : (which == 1) ? n_fd : n_disp;
    end
    check(what, v >= target, 1);
  endtask

  task automatic wait_addr(input int addr, input int budget, input string what);
    int i;
    i = 0;
    while (rd_addr != addr && i < budget) begin
      tick(1);
      i = i + 1;
    end
    check(what, rd_addr, addr);
  endtask

  task automatic wait_oe_low(input int budget);
    int i;
    i = 0;
    while (OE && i < budget) begin
      tick(1);
      i = i + 1;
    end
    check("wait_display", OE, 0);
  endtask

  initial begin
    int sclk_snap;

    reset = 1'b0;
    run   = 1'b0;
    dim   = 2'd0;
    tick(5);
    check("rst_oe", OE, 1);
    check("rst_lat", LAT, 0);
    check("rst_sclk", sclk, 0);
    check("rst_addr", rd_addr, 0);
    check("rst_fd", frame_done, 0);
    reset = 1'b1;

    // Idle with run low: nothing moves.
    tick(100);
    check("idle_sclk_rises", n_sclk, 0);
    check("idle_lat_rises", n_lat, 0);
    check("idle_oe_low_clks", n_oe_low, 0);
    check("idle_frame_done", n_fd, 0);
    check("idle_addr", rd_addr, 0);
    check("idle_oe", OE, 1);

    // Full frame, then rows 0..3 of the next frame with run dropped at {3,10}.
    push_row(0, 0, 64);
    for (int r = 1; r < ROWS_HALF; r++) push_row(r, ROW_CLKS, 64);
    for (int r = 0; r < 4; r++) push_row(r, ROW_CLKS, 64);
    fd_q.push_back(cyc + 1 + FRAME_CLKS);
    run = 1'b1;
    wait_count(1, 1, FRAME_CLKS + 50, "wait_frame_done");
    wait_addr(106, 4 * ROW_CLKS, "wait_row3_col10");
    run = 1'b0;
    wait_count(2, 20, 2 * ROW_CLKS, "wait_row3_display");

    // Parked in IDLE after row 3.
    sclk_snap = n_sclk;
    tick(30);
    check("park_sclk_rises", n_sclk - sclk_snap, 0);
    check("park_oe", OE, 1);
    check("park_lat", LAT, 0);
    check("park_addr", rd_addr, 127);

    // Resume at row 4 (optionally dimmed), then reset inside row 5's dwell.
    dim = 2'd2;
    push_row(4, 0, ROW4_OE);
    push_row(5, 163 + ROW4_OE, 64);
    run = 1'b1;
    tick(1);
    check("resume_addr", rd_addr, 128);
    wait_count(0, 22, 2 * ROW_CLKS, "wait_row5_lat");
    wait_oe_low(20);
    tick(5);
    reset = 1'b0;
    #1;
    check("async_oe", OE, 1);
    check("async_rowD", rowD, 0);
    check("async_lat", LAT, 0);
    check("async_sclk", sclk, 0);
    check("async_addr", rd_addr, 0);
    run = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(20);
    check("post_rst_lat_rises", n_lat, 22);
    check("post_rst_oe", OE, 1);
    check("post_rst_addr", rd_addr, 0);

    check("pix_queue_empty", pix_q.size(), 0);
    check("row_queue_empty", row_q.size(), 0);
    check("fd_queue_empty", fd_q.size(), 0);
    check("frame_done_total", n_fd, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
